// File: rtl/cpu16_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu16_io_responder
// Description : I/O port responder for the CPU16 IN/OUT/WAIT instructions.
//               It buffers outbound words in a TX FIFO and inbound words in an
//               RX FIFO. A req/ack handshake stalls the core while the
//               addressed FIFO cannot serve the access.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu16_io_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_req,
  input  logic                  io_write,
  input  logic [7:0]            io_port,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  io_ack,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] PORT_DATA   = 8'h00;
  localparam logic [7:0] PORT_STATUS = 8'h01;
  localparam logic [7:0] PORT_CTRL   = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PTR_W-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [DATA_WIDTH-1:0] io_rdata_q, io_rdata_d;

  logic is_data, can_complete, do_access;
  logic cpu_tx_push, cpu_rx_pop, ctrl_wr, flush_tx, flush_rx;
  logic dev_tx_pop, dev_rx_push, rx_store;
  logic [DATA_WIDTH-1:0] status_word;

  assign tx_valid = (tx_count_q != '0);
  assign rx_ready = (rx_count_q != DEPTH_C);
  assign tx_data  = tx_mem[tx_rptr_q];
  assign io_ack   = (state_q == ST_DONE);
  assign io_rdata = io_rdata_q;

  // Handshake next-state: decide from registered counts whether the access can finish now.
  always_comb begin
    state_d      = state_q;
    do_access    = 1'b0;
    is_data      = (io_port == PORT_DATA);
    can_complete = !is_data ||
                   (io_write ? (tx_count_q != DEPTH_C) : (rx_count_q != '0));
    case (state_q)
      ST_IDLE: begin
        if (io_req) begin
          if (can_complete) begin
            do_access = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Dropping req while stalled abandons the access.
        if (!io_req) begin
          state_d = ST_IDLE;
        end else if (can_complete) begin
          do_access = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!io_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping and read-data selection for the access completing this edge.
  always_comb begin
    cpu_tx_push = do_access &  io_write & is_data;
    cpu_rx_pop  = do_access & ~io_write & is_data;
    ctrl_wr     = do_access &  io_write & (io_port == PORT_CTRL);
    flush_rx    = ctrl_wr & io_wdata[0];
    flush_tx    = ctrl_wr & io_wdata[1];
    dev_tx_pop  = tx_valid & tx_ready;
    dev_rx_push = rx_ready & rx_valid;
    rx_store    = dev_rx_push & ~flush_rx;

    status_word       = '0;
    status_word[15:8] = 8'(rx_count_q);
    status_word[7:0]  = 8'(tx_count_q);

    if (flush_tx) begin
      tx_count_d = '0;
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
    end else begin
      tx_count_d = tx_count_q + CNT_W'(cpu_tx_push) - CNT_W'(dev_tx_pop);
      tx_wptr_d  = tx_wptr_q + PTR_W'(cpu_tx_push);
      tx_rptr_d  = tx_rptr_q + PTR_W'(dev_tx_pop);
    end

    if (flush_rx) begin
      rx_count_d = '0;
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
    end else begin
      rx_count_d = rx_count_q + CNT_W'(dev_rx_push) - CNT_W'(cpu_rx_pop);
      rx_wptr_d  = rx_wptr_q + PTR_W'(dev_rx_push);
      rx_rptr_d  = rx_rptr_q + PTR_W'(cpu_rx_pop);
    end

    io_rdata_d = io_rdata_q;
    if (do_access && !io_write) begin
      case (io_port)
        PORT_DATA:   io_rdata_d = rx_mem[rx_rptr_q];
        PORT_STATUS: io_rdata_d = status_word;
        default:     io_rdata_d = '0;
      endcase
    end
  end

  // State, pointers, counts and read data; reset empties both FIFOs at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      io_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_count_q <= tx_count_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_count_q <= rx_count_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // FIFO storage; contents need no reset because the counts gate visibility.
  always_ff @(posedge clock) begin
    if (cpu_tx_push) tx_mem[tx_wptr_q] <= io_wdata;
    if (rx_store)    rx_mem[rx_wptr_q] <= rx_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu16_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu16_io_responder
// Description : Directed self-checking bench for cpu16_io_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu16_io_responder;

  localparam int BUDGET = 50;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_req = 1'b0;
  logic        io_write = 1'b0;
  logic [7:0]  io_port = 8'h00;
  logic [15:0] io_wdata = 16'h0000;
  logic [15:0] io_rdata;
  logic        io_ack;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = 16'h0000;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int n_cmp = 0;
  int n_err = 0;

  cpu16_io_responder #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .io_req(io_req), .io_write(io_write), .io_port(io_port),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  // Full CPU transaction; cycles = edges until ack, or -1 when the budget expires.
  task automatic cpu_access(input logic wr, input logic [7:0] port, input logic [15:0] wd,
                            output logic [15:0] rd, output int cycles);
    io_write = wr; io_port = port; io_wdata = wd; io_req = 1'b1;
    cycles = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clock); #1;
      if (io_ack) begin cycles = i; break; end
    end
    rd = io_rdata;
    io_req = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic dev_push(input logic [15:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_tx_ready();
    tx_ready = 1'b1;
    @(posedge clock); #1;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (io_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", io_ack); end
    n_cmp++; if (io_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata got=%h exp=0000", io_rdata); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_out();
    logic [15:0] rd; int cyc;
    tx_ready = 1'b0;
    cpu_access(1'b1, 8'h00, 16'h1234, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL out_latency got=%0d exp=1", cyc); end
    n_cmp++; if (io_ack !== 1'b0) begin n_err++; $display("FAIL out_ack_drop got=%b exp=0", io_ack); end
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL out_tx_valid got=%b exp=1", tx_valid); end
    n_cmp++; if (tx_data !== 16'h1234) begin n_err++; $display("FAIL out_tx_data got=%h exp=1234", tx_data); end
    pulse_tx_ready();
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL out_drain got=%b exp=0", tx_valid); end
  endtask

  task automatic test_in();
    logic [15:0] rd; int cyc;
    dev_push(16'hA5A5);
    dev_push(16'h5A5A);
    cpu_access(1'b0, 8'h00, 16'h0000, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL in1_latency got=%0d exp=1", cyc); end
    n_cmp++; if (rd !== 16'hA5A5) begin n_err++; $display("FAIL in1_data got=%h exp=a5a5", rd); end
    cpu_access(1'b0, 8'h00, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h5A5A) begin n_err++; $display("FAIL in2_data got=%h exp=5a5a", rd); end
    cpu_access(1'b0, 8'h01, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL in_status got=%h exp=0000", rd); end
  endtask

  task automatic test_stall_read();
    int early_acks;
    early_acks = 0;
    io_write = 1'b0; io_port = 8'h00; io_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (io_ack) early_acks++;
    end
    n_cmp++; if (early_acks !== 0) begin n_err++; $display("FAIL stall_wait acks=%0d exp=0", early_acks); end
    dev_push(16'h00FF);
    n_cmp++; if (io_ack !== 1'b0) begin n_err++; $display("FAIL stall_push_edge got=%b exp=0", io_ack); end
    @(posedge clock); #1;
    n_cmp++; if (io_ack !== 1'b1) begin n_err++; $display("FAIL stall_ack got=%b exp=1", io_ack); end
    n_cmp++; if (io_rdata !== 16'h00FF) begin n_err++; $display("FAIL stall_data got=%h exp=00ff", io_rdata); end
    io_req = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (io_ack !== 1'b0) begin n_err++; $display("FAIL stall_release got=%b exp=0", io_ack); end
  endtask

  task automatic test_tx_full();
    logic [15:0] rd; int cyc; int bad_lat;
    logic [15:0] words [4];
    logic [15:0] order [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    order[0] = 16'h2222; order[1] = 16'h3333; order[2] = 16'h4444; order[3] = 16'h5555;
    tx_ready = 1'b0;
    bad_lat = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_access(1'b1, 8'h00, words[i], rd, cyc);
      if (cyc != 1) bad_lat++;
    end
    n_cmp++; if (bad_lat !== 0) begin n_err++; $display("FAIL fill_latency slow=%0d exp=0", bad_lat); end
    cpu_access(1'b0, 8'h01, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h0004) begin n_err++; $display("FAIL fill_status got=%h exp=0004", rd); end
    io_write = 1'b1; io_port = 8'h00; io_wdata = 16'h5555; io_req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (io_ack !== 1'b0) begin n_err++; $display("FAIL full_stall got=%b exp=0", io_ack); end
    pulse_tx_ready();
    n_cmp++; if (io_ack !== 1'b0) begin n_err++; $display("FAIL full_pop_edge got=%b exp=0", io_ack); end
    @(posedge clock); #1;
    n_cmp++; if (io_ack !== 1'b1) begin n_err++; $display("FAIL full_ack got=%b exp=1", io_ack); end
    io_req = 1'b0;
    @(posedge clock); #1;
    cpu_access(1'b0, 8'h01, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h0004) begin n_err++; $display("FAIL full_status got=%h exp=0004", rd); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tx_data !== order[i]) begin n_err++; $display("FAIL tx_order[%0d] got=%h exp=%h", i, tx_data, order[i]); end
      pulse_tx_ready();
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_flush();
    logic [15:0] rd; int cyc;
    cpu_access(1'b1, 8'h00, 16'hBEEF, rd, cyc);
    for (int i = 0; i < 4; i++) dev_push(16'h0100 + 16'(i));
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_full got=%b exp=0", rx_ready); end
    cpu_access(1'b0, 8'h01, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h0401) begin n_err++; $display("FAIL pre_flush_status got=%h exp=0401", rd); end
    cpu_access(1'b1, 8'h02, 16'h0003, rd, cyc);
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL flush_rx_ready got=%b exp=1", rx_ready); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL flush_tx_valid got=%b exp=0", tx_valid); end
    cpu_access(1'b0, 8'h01, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL flush_status got=%h exp=0000", rd); end
    cpu_access(1'b0, 8'h07, 16'h0000, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL port7_latency got=%0d exp=1", cyc); end
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL port7_data got=%h exp=0000", rd); end
    cpu_access(1'b0, 8'h02, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL ctrl_read got=%h exp=0000", rd); end
  endtask

  task automatic test_reset_wait();
    logic [15:0] rd; int cyc;
    tx_ready = 1'b0;
    cpu_access(1'b1, 8'h00, 16'hCAFE, rd, cyc);
    io_write = 1'b0; io_port = 8'h00; io_req = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (io_ack !== 1'b0) begin n_err++; $display("FAIL rst_wait_ack got=%b exp=0", io_ack); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_wait_tx_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rst_wait_rx_ready got=%b exp=1", rx_ready); end
    io_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    cpu_access(1'b1, 8'h00, 16'h7777, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL post_rst_latency got=%0d exp=1", cyc); end
    n_cmp++; if (tx_data !== 16'h7777) begin n_err++; $display("FAIL post_rst_tx_data got=%h exp=7777", tx_data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int cyc;
    dev_push(16'h0042);
    cpu_access(1'b0, 8'h01, 16'h0000, rd, cyc);
    n_cmp++; if (rd !== 16'h0101) begin n_err++; $display("FAIL b2b_status got=%h exp=0101", rd); end
    cpu_access(1'b0, 8'h00, 16'h0000, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL b2b_latency got=%0d exp=1", cyc); end
    n_cmp++; if (rd !== 16'h0042) begin n_err++; $display("FAIL b2b_data got=%h exp=0042", rd); end
  endtask

  initial begin
    test_reset();
    test_out();
    test_in();
    test_stall_read();
    test_tx_full();
    test_flush();
    test_reset_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
